wlogic_prog: RTL and testbench
==============================

Name:
wlogic_prog

Overview:
Parametrised next-generation write-side controller for the async FIFO. It owns the binary and Gray write pointers and synchronises the reader's Gray pointer through a configurable-depth synchroniser. It generates full, a programmable almost-full, a registered fill level and a sticky overflow flag. It sits in the write clock domain between the writing circuit and the dual-port FIFO buffer, and pairs with the read-side logic.

Parameters:
AWIDTH, 4, address width; FIFO depth = 2^AWIDTH; pointers are AWIDTH+1 bits (extra MSB = wrap bit); legal AWIDTH >= 2.
SYNC_STAGES, 2, flops in the rgray synchroniser chain; legal >= 2.

Ports:
wclk  input  1  writing circuit's clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
wdv  input  1  write data valid; a write is accepted when wdv=1 and wfull=0.
rgray  input  AWIDTH+1  Gray read pointer from the read domain (asynchronous to wclk).
afull_thresh  input  AWIDTH+1  almost-full threshold in words; quasi-static.
ovf_clr  input  1  clears the sticky overflow flag.
wgray  output  AWIDTH+1  registered Gray write pointer to the read domain.
waddr  output  AWIDTH  write address to the buffer = wbin[AWIDTH-1:0].
wen  output  1  buffer write enable = wdv & ~wfull (combinational).
wfull  output  1  registered FIFO-full flag.
wafull  output  1  registered almost-full flag.
wlevel  output  AWIDTH+1  registered word count as seen by the writer, range 0..2^AWIDTH.
woverflow  output  1  sticky flag: a write was attempted while full.

Behaviour:
- Reset: rst sampled at the wclk edge (synchronous, active-high).
- On reset, all state clears to 0 on that edge: wbin, wgray, all sync stages, wfull, wafull, wlevel, woverflow.
- Consequently waddr=0 and wen=wdv after reset.
- Reset mid-operation discards pointer state; there is no partial-state retention.
- Synchroniser: rgray passes through SYNC_STAGES flops, output rsync. rbin = gray2bin(rsync), combinational.
- Next pointer: wbin_next = wbin + 1 when wen=1, else wbin. Arithmetic is modulo 2^(AWIDTH+1), so the wrap from all-ones to 0 toggles the MSB.
- Pointer registers: wbin <= wbin_next; wgray <= bin2gray(wbin_next). wgray is a pure flop output, never a combinational value, and changes at most one bit per cycle.
- Level: lvl_next = (wbin_next - rbin) mod 2^(AWIDTH+1). wlevel <= lvl_next.
- Full: wfull <= (lvl_next == 2^AWIDTH). This is equivalent to {~wbin_next[AWIDTH], wbin_next[AWIDTH-1:0]} == rbin.
- Almost full: wafull <= (lvl_next >= afull_thresh), an unsigned compare.
  - afull_thresh=0: wafull is 1 from the first cycle after reset.
  - afull_thresh > 2^AWIDTH: wafull never asserts.
- Timing: the full flags assert in the cycle after the write that fills the last slot. The writer never overruns because wen is gated by the registered wfull.
- Read-pointer latency: an rgray change affects wfull, wafull and wlevel exactly SYNC_STAGES+1 wclk edges later.
- The level is pessimistic (may over-report fill), never under-reports.
- Simultaneous write accepted and read pointer advance in the same edge: the level reflects both, so the net change is 0.
- Overflow:
  - woverflow sets when wdv=1 and wfull=1 at an edge.
  - ovf_clr=1 clears it.
  - Set and clear in the same cycle: set wins, woverflow=1.
  - An overflowed write has no pointer effect: wbin and wgray hold, wen=0.
- Write while full with the read pointer advancing: the write is still rejected in that cycle, because wfull is registered. It is accepted once wfull drops.
- Empty: no empty logic on this side. wlevel=0 means empty as seen by the writer.

Test Plan:
1. AWIDTH=4, SYNC=2, rgray=0. Reset, then wdv=1 for 20 cycles. Required: wen=1 for 16 cycles; waddr 0..15; wfull=1 after the 16th write edge; wlevel=16; wgray=5'b11000; woverflow=1 after the 17th attempt.
2. afull_thresh=12. Write 11 words: wafull=0. Write the 12th: wafull=1 on the next cycle, wlevel=12.
3. From full, drive rgray=bin2gray(4)=5'b00110. Required: wfull=0 and wlevel=12 exactly 3 edges later; the next write is accepted with waddr=0.
4. Wrap test: 40 writes interleaved with read-pointer advances. Required: wbin MSB toggles at 16 and 32; each wgray step has Hamming distance 1; wfull never falsely asserts.
5. ovf_clr asserted in the same cycle as a further write-while-full: woverflow stays 1. Next cycle, wdv=0 with ovf_clr=1: woverflow=0.
6. Assert rst mid-burst at wlevel=7. Required: all outputs 0 on that edge; the first write after release uses waddr=0.

Source files
------------

// File: rtl/wlogic_prog.sv
// Write-side controller for the async FIFO: binary/Gray write pointers, read-pointer
// synchroniser, and registered full, almost-full, level and sticky overflow flags.
module wlogic_prog #(
    parameter int AWIDTH      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              wclk,
    input  logic              rst,
    input  logic              wdv,
    input  logic [AWIDTH:0]   rgray,
    input  logic [AWIDTH:0]   afull_thresh,
    input  logic              ovf_clr,
    output logic [AWIDTH:0]   wgray,
    output logic [AWIDTH-1:0] waddr,
    output logic              wen,
    output logic              wfull,
    output logic              wafull,
    output logic [AWIDTH:0]   wlevel,
    output logic              woverflow
);
    localparam int PW = AWIDTH + 1;
    localparam logic [PW-1:0] FULL_LVL = {1'b1, {AWIDTH{1'b0}}};

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] rgray_p [SYNC_STAGES];
    logic [PW-1:0] rsync;
    logic [PW-1:0] rbin;
    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] lvl_next;

    // Read-pointer synchroniser: rgray is asynchronous, only Gray code may cross here
    always_ff @(posedge wclk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rgray_p[i] <= '0;
            end
        end else begin
            rgray_p[0] <= rgray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rgray_p[i] <= rgray_p[i-1];
            end
        end
    end

    assign rsync     = rgray_p[SYNC_STAGES-1];
    assign rbin      = gray2bin(rsync);

    // Gating with the registered wfull means an accepted write can never overrun the buffer
    assign wen       = wdv & ~wfull;
    assign wbin_next = wbin + PW'(wen);
    assign lvl_next  = wbin_next - rbin;
    assign waddr     = wbin[AWIDTH-1:0];

    // Pointer and flag registers, all computed from the post-write pointer
    always_ff @(posedge wclk) begin
        if (rst) begin
            wbin      <= '0;
            wgray     <= '0;
            wlevel    <= '0;
            wfull     <= 1'b0;
            wafull    <= 1'b0;
            woverflow <= 1'b0;
        end else begin
            wbin      <= wbin_next;
            wgray     <= bin2gray(wbin_next);
            wlevel    <= lvl_next;
            wfull     <= (lvl_next == FULL_LVL);
            wafull    <= (lvl_next >= afull_thresh);
            woverflow <= (wdv & wfull) | (woverflow & ~ovf_clr);
        end
    end

endmodule

// File: tb/tb_wlogic_prog.sv
// Directed bench for wlogic_prog (AWIDTH=4, SYNC_STAGES=2): vector table plus
// hand-written sequences for reset, threshold boundaries and pointer wrap.
module tb_wlogic_prog;
    logic       wclk = 1'b0;
    logic       rst = 1'b0;
    logic       wdv = 1'b0;
    logic [4:0] rgray = '0;
    logic [4:0] afull_thresh = 5'd12;
    logic       ovf_clr = 1'b0;
    logic [4:0] wgray;
    logic [3:0] waddr;
    logic       wen;
    logic       wfull;
    logic       wafull;
    logic [4:0] wlevel;
    logic       woverflow;

    int n_checks = 0;
    int n_errors = 0;

    wlogic_prog #(.AWIDTH(4), .SYNC_STAGES(2)) dut (
        .wclk(wclk), .rst(rst), .wdv(wdv), .rgray(rgray), .afull_thresh(afull_thresh),
        .ovf_clr(ovf_clr), .wgray(wgray), .waddr(waddr), .wen(wen), .wfull(wfull),
        .wafull(wafull), .wlevel(wlevel), .woverflow(woverflow)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic       rst, wdv, ovf_clr;
        logic [4:0] rgray;
        logic       chk_pre;
        logic       pre_wen;
        logic [3:0] pre_waddr;
        logic [4:0] exp_wgray;
        logic [3:0] exp_waddr;
        logic       exp_wfull, exp_wafull;
        logic [4:0] exp_wlevel;
        logic       exp_wovf;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [4:0] gray(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic add(input logic r, input logic d, input logic c, input logic [4:0] rg,
                       input logic cp, input logic pw, input int pa,
                       input logic [4:0] eg, input int ea, input logic ef, input logic eaf,
                       input int el, input logic eo);
        vec_t v;
        v.rst = r; v.wdv = d; v.ovf_clr = c; v.rgray = rg;
        v.chk_pre = cp; v.pre_wen = pw; v.pre_waddr = 4'(pa);
        v.exp_wgray = eg; v.exp_waddr = 4'(ea); v.exp_wfull = ef; v.exp_wafull = eaf;
        v.exp_wlevel = 5'(el); v.exp_wovf = eo;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, then let the rising edge happen and sample 1 time unit later.
    task automatic drive(input logic r, input logic d, input logic c, input logic [4:0] rg);
        @(negedge wclk);
        rst = r; wdv = d; ovf_clr = c; rgray = rg;
    endtask

    task automatic settle();
        @(posedge wclk);
        #1;
    endtask

    function automatic logic [16:0] post_bundle();
        return {wgray, waddr, wfull, wafull, wlevel, woverflow};
    endfunction

    initial begin
        int k;
        int rd [40];
        logic [4:0] prev_g;

        // Tests 1/2: reset, then 20 write attempts with rgray=0 and threshold 12
        add(1, 0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            k = (i + 1 > 16) ? 16 : i + 1;
            add(0, 1, 0, 0, 1, (i < 16), (i < 16) ? i : 0,
                gray(k), k & 15, (k == 16), (k >= 12), k, (i >= 16));
        end
        // Test 3: read pointer jumps to 4; flags react on the third edge
        add(0, 0, 0, 5'b00110, 1, 0, 0, gray(16), 0, 1, 1, 16, 1);
        add(0, 0, 0, 5'b00110, 1, 0, 0, gray(16), 0, 1, 1, 16, 1);
        add(0, 0, 0, 5'b00110, 1, 0, 0, gray(16), 0, 0, 1, 12, 1);
        add(0, 1, 0, 5'b00110, 1, 1, 0, gray(17), 1, 0, 1, 13, 1);
        // Test 5: clear, refill, then set and clear together, then clear alone
        add(0, 0, 1, 5'b00110, 1, 0, 1, gray(17), 1, 0, 1, 13, 0);
        add(0, 1, 0, 5'b00110, 1, 1, 1, gray(18), 2, 0, 1, 14, 0);
        add(0, 1, 0, 5'b00110, 1, 1, 2, gray(19), 3, 0, 1, 15, 0);
        add(0, 1, 0, 5'b00110, 1, 1, 3, gray(20), 4, 1, 1, 16, 0);
        add(0, 1, 1, 5'b00110, 1, 0, 4, gray(20), 4, 1, 1, 16, 1);
        add(0, 0, 1, 5'b00110, 1, 0, 4, gray(20), 4, 1, 1, 16, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].wdv, vecs[i].ovf_clr, vecs[i].rgray);
            #1;
            if (vecs[i].chk_pre) begin
                check($sformatf("vec%0d wen/waddr", i), {wen, waddr},
                      {vecs[i].pre_wen, vecs[i].pre_waddr});
            end
            settle();
            check($sformatf("vec%0d outputs", i), post_bundle(),
                  {vecs[i].exp_wgray, vecs[i].exp_waddr, vecs[i].exp_wfull,
                   vecs[i].exp_wafull, vecs[i].exp_wlevel, vecs[i].exp_wovf});
        end

        // Test 6: reset in the middle of a burst at level 7
        drive(1, 0, 0, 5'd0);
        settle();
        for (int i = 0; i < 7; i++) begin
            drive(0, 1, 0, 5'd0);
            settle();
        end
        check("burst level 7", wlevel, 32'd7);
        drive(1, 1, 0, 5'd0);
        settle();
        check("mid-burst reset outputs", post_bundle(), 17'd0);
        drive(0, 1, 0, 5'd0);
        #1;
        check("first write after reset", {wen, waddr}, {1'b1, 4'd0});
        settle();
        check("level after first write", {wlevel, waddr}, {5'd1, 4'd1});

        // Threshold 0: almost-full from the first cycle after reset
        afull_thresh = 5'd0;
        drive(1, 0, 0, 5'd0);
        settle();
        check("thresh0 wafull at reset", wafull, 32'd0);
        drive(0, 0, 0, 5'd0);
        settle();
        check("thresh0 wafull after reset", wafull, 32'd1);

        // Threshold 17 exceeds depth: never almost-full, even when full
        afull_thresh = 5'd17;
        drive(1, 0, 0, 5'd0);
        settle();
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 0, 5'd0);
            settle();
        end
        check("thresh17 full", {wfull, wafull, wlevel}, {1'b1, 1'b0, 5'd16});

        // Test 4: 40 writes with the reader trailing 4 words behind
        afull_thresh = 5'd12;
        drive(1, 0, 0, 5'd0);
        settle();
        prev_g = wgray;
        for (int e = 0; e < 40; e++) begin
            rd[e] = (e >= 4) ? e - 4 : 0;
            drive(0, 1, 0, gray(rd[e]));
            #1;
            check($sformatf("wrap%0d wen", e), {wen, waddr}, {1'b1, 4'(e)});
            settle();
            check($sformatf("wrap%0d wgray", e), wgray, gray(e + 1));
            check($sformatf("wrap%0d gray step", e), $countones(wgray ^ prev_g), 32'd1);
            check($sformatf("wrap%0d wfull", e), wfull, 32'd0);
            check($sformatf("wrap%0d wlevel", e), wlevel,
                  32'((e + 1) - ((e >= 2) ? rd[e-2] : 0)));
            if (e + 1 == 16 || e + 1 == 32) begin
                check($sformatf("wrap msb at %0d", e + 1), wgray[4], (e + 1 == 16) ? 32'd1 : 32'd0);
            end
            prev_g = wgray;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
